// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit.
// Build option: MIPS_ILLEGAL_OPCODE_TRAP_EN adds a sticky TRAP state and trap output.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W    = 6;
    localparam int unsigned ALUOP_W     = 3;
    localparam int unsigned STATE_ENC_W = 4;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b101;

    typedef enum logic [STATE_ENC_W-1:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_R_EXEC    = 4'd3,
        S_R_WB      = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_I_EXEC    = 4'd11,
        S_I_WB      = 4'd12,
        S_TRAP      = 4'd13,
        S_INVALID   = 4'd15
    } state_e;

    // Datapath control word produced from (state, latched opcode)
    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic               branch_ne;
        logic [1:0]         pc_src;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
`ifdef MIPS_ILLEGAL_OPCODE_TRAP_EN
        logic               trap;
`endif
    } ctrl_t;

    // ALU operation for the immediate-arithmetic group
    function automatic logic [ALUOP_W-1:0] i_exec_aluop(input logic [OPCODE_W-1:0] op);
        logic [ALUOP_W-1:0] r;
        case (op)
            OP_ANDI: r = ALUOP_AND;
            OP_ORI:  r = ALUOP_OR;
            OP_SLTI: r = ALUOP_SLT;
            default: r = ALUOP_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_ctrl_output_decode.sv
// Combinational Moore decode: (state, latched opcode) -> datapath control word.
// Build option: MIPS_ILLEGAL_OPCODE_TRAP_EN drives the trap bit in TRAP.
module mips_ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e                state,
    input  logic [OPCODE_W-1:0]   opcode,
    output ctrl_t                 ctrl
);

    // Per-state enables; anything not set stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = 2'b01;
                ctrl.branch_ne     = opcode[0];
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = 2'b10;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = i_exec_aluop(opcode);
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
`ifdef MIPS_ILLEGAL_OPCODE_TRAP_EN
            S_TRAP: begin
                ctrl.trap = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: state and opcode registers plus next-state logic.
// Build option: MIPS_ILLEGAL_OPCODE_TRAP_EN routes unknown opcodes to a sticky TRAP state.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_src,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
`ifdef MIPS_ILLEGAL_OPCODE_TRAP_EN
    output logic                trap,
`endif
    output logic [ALUOP_W-1:0]  ALUop
);

    logic [STATE_W-1:0]  state_q;
    logic [OPCODE_W-1:0] opcode_q;
    state_e              state_c;
    ctrl_t               ctrl_c;
    logic                fetch_done_c;

    function automatic logic [STATE_W-1:0] enc(input state_e s);
        return STATE_W'(s);
    endfunction

    // Interpret the state register; any bit above the encoding marks it invalid
    always_comb begin
        state_c = state_e'(state_q[STATE_ENC_W-1:0]);
        if ((state_q >> STATE_ENC_W) != '0) begin
            state_c = S_INVALID;
        end
    end

    // State and latched-opcode registers with inline next-state selection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= '0;
            opcode_q <= '0;
        end else begin
            case (state_c)
                S_IDLE:      state_q <= enc(S_FETCH);
                S_FETCH:     state_q <= mem_ready ? enc(S_DECODE) : enc(S_FETCH);
                S_DECODE: begin
                    opcode_q <= opcode;
                    case (opcode)
                        OP_RTYPE:                         state_q <= enc(S_R_EXEC);
                        OP_LW, OP_SW:                     state_q <= enc(S_MEM_ADDR);
                        OP_BEQ, OP_BNE:                   state_q <= enc(S_BRANCH);
                        OP_J:                             state_q <= enc(S_JUMP);
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_q <= enc(S_I_EXEC);
`ifdef MIPS_ILLEGAL_OPCODE_TRAP_EN
                        default:                          state_q <= enc(S_TRAP);
`else
                        default:                          state_q <= enc(S_FETCH);
`endif
                    endcase
                end
                S_R_EXEC:    state_q <= enc(S_R_WB);
                S_R_WB:      state_q <= enc(S_FETCH);
                S_MEM_ADDR:  state_q <= (opcode_q == OP_SW) ? enc(S_MEM_WRITE) : enc(S_MEM_READ);
                S_MEM_READ:  state_q <= mem_ready ? enc(S_MEM_WB) : enc(S_MEM_READ);
                S_MEM_WB:    state_q <= enc(S_FETCH);
                S_MEM_WRITE: state_q <= mem_ready ? enc(S_FETCH) : enc(S_MEM_WRITE);
                S_BRANCH:    state_q <= enc(S_FETCH);
                S_JUMP:      state_q <= enc(S_FETCH);
                S_I_EXEC:    state_q <= enc(S_I_WB);
                S_I_WB:      state_q <= enc(S_FETCH);
`ifdef MIPS_ILLEGAL_OPCODE_TRAP_EN
                S_TRAP:      state_q <= enc(S_TRAP);
`endif
                default:     state_q <= enc(S_IDLE);
            endcase
        end
    end

    mips_ctrl_output_decode u_decode (
        .state  (state_c),
        .opcode (opcode_q),
        .ctrl   (ctrl_c)
    );

    // Instruction fetch completes on the handshake cycle: latch IR and advance PC
    assign fetch_done_c  = (state_c == S_FETCH) && mem_ready;

    assign pc_write      = ctrl_c.pc_write | fetch_done_c;
    assign ir_write      = fetch_done_c;
    assign pc_write_cond = ctrl_c.pc_write_cond;
    assign branch_ne     = ctrl_c.branch_ne;
    assign pc_src        = ctrl_c.pc_src;
    assign i_or_d        = ctrl_c.i_or_d;
    assign mem_read      = ctrl_c.mem_read;
    assign mem_write     = ctrl_c.mem_write;
    assign reg_write     = ctrl_c.reg_write;
    assign reg_dst       = ctrl_c.reg_dst;
    assign mem_to_reg    = ctrl_c.mem_to_reg;
    assign alu_src_a     = ctrl_c.alu_src_a;
    assign alu_src_b     = ctrl_c.alu_src_b;
    assign ALUop         = ctrl_c.alu_op;
`ifdef MIPS_ILLEGAL_OPCODE_TRAP_EN
    assign trap          = ctrl_c.trap;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: the driver queues the expected
// control word for every cycle it drives, the monitor checks it on the falling edge.
`timescale 1ns/1ps
module tb_mips_multicycle_control;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ORI   = 6'b001101;
    localparam logic [5:0] T_ILL   = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] ALUop;
    logic       trap_obs;

    always #5 clk = ~clk;

`ifdef MIPS_ILLEGAL_OPCODE_TRAP_EN
    logic trap;
    assign trap_obs = trap;
`else
    assign trap_obs = 1'b0;
`endif

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_src        (pc_src),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
`ifdef MIPS_ILLEGAL_OPCODE_TRAP_EN
        .trap          (trap),
`endif
        .ALUop         (ALUop)
    );

    typedef struct {
        logic [18:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [18:0] actual;
    assign actual = {trap_obs, pc_write, pc_write_cond, branch_ne, pc_src, i_or_d,
                     mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, ALUop};

    function automatic logic [18:0] cw(input logic trp, input logic pcw, input logic pcc,
                                       input logic bne, input logic [1:0] psrc,
                                       input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic rw, input logic rd,
                                       input logic m2r, input logic asa,
                                       input logic [1:0] asb, input logic [2:0] op);
        return {trp, pcw, pcc, bne, psrc, iord, mr, mw, irw, rw, rd, m2r, asa, asb, op};
    endfunction

    logic [18:0] E_IDLE, E_FWAIT, E_FDONE, E_DEC, E_REX, E_RWB, E_MADDR, E_MRD, E_MWB;
    logic [18:0] E_MWR, E_BNE, E_BEQ, E_JMP, E_IORI, E_IWB, E_TRAP;

    // Drive one cycle's inputs just after the rising edge and queue that cycle's expectation
    task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                        input logic [18:0] e, input string nm);
        exp_t t;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        t.exp  = e;
        t.name = nm;
        sb_q.push_back(t);
    endtask

    // Monitor: compare the live control word against the oldest queued expectation
    initial begin : monitor
        exp_t t;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                t = sb_q.pop_front();
                n_checks++;
                if (actual !== t.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b (t=%0t)", t.name, actual, t.exp, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        //          trp pcw pcc bne psrc  iord mr mw irw rw rd m2r asa asb    op
        E_IDLE  = '0;
        E_FWAIT = cw(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000);
        E_FDONE = cw(0, 1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000);
        E_DEC   = cw(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000);
        E_REX   = cw(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010);
        E_RWB   = cw(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000);
        E_MADDR = cw(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000);
        E_MRD   = cw(0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        E_MWB   = cw(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000);
        E_MWR   = cw(0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        E_BNE   = cw(0, 0, 1, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001);
        E_BEQ   = cw(0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001);
        E_JMP   = cw(0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        E_IORI  = cw(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100);
        E_IWB   = cw(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000);
        E_TRAP  = cw(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);

        // Reset for two cycles, then one IDLE cycle, then FETCH
        step(1, T_RTYPE, 1, E_IDLE,  "reset_c1");
        step(1, T_RTYPE, 1, E_IDLE,  "reset_c2");
        step(0, T_RTYPE, 1, E_IDLE,  "idle_after_reset");
        step(0, T_RTYPE, 1, E_FDONE, "fetch_first");

        // R-type: back in FETCH on the fifth cycle
        step(0, T_RTYPE, 1, E_DEC,   "rtype_decode");
        step(0, T_RTYPE, 0, E_REX,   "rtype_exec");
        step(0, T_RTYPE, 0, E_RWB,   "rtype_wb");
        step(0, T_LW,    1, E_FDONE, "rtype_next_fetch");

        // lw with three wait cycles in MEM_READ
        step(0, T_LW,    1, E_DEC,   "lw_decode");
        step(0, T_RTYPE, 0, E_MADDR, "lw_addr");
        step(0, T_RTYPE, 0, E_MRD,   "lw_read_w1");
        step(0, T_RTYPE, 0, E_MRD,   "lw_read_w2");
        step(0, T_RTYPE, 0, E_MRD,   "lw_read_w3");
        step(0, T_RTYPE, 1, E_MRD,   "lw_read_done");
        step(0, T_RTYPE, 1, E_MWB,   "lw_wb");

        // FETCH stalled for one cycle
        step(0, T_BNE,   0, E_FWAIT, "fetch_stall");
        step(0, T_BNE,   1, E_FDONE, "fetch_after_stall");

        // bne then beq
        step(0, T_BNE,   1, E_DEC,   "bne_decode");
        step(0, T_RTYPE, 0, E_BNE,   "bne_branch");
        step(0, T_BEQ,   1, E_FDONE, "bne_next_fetch");
        step(0, T_BEQ,   1, E_DEC,   "beq_decode");
        step(0, T_BEQ,   1, E_BEQ,   "beq_branch");
        step(0, T_ORI,   1, E_FDONE, "beq_next_fetch");

        // ori, with opcode input changed during I_EXEC
        step(0, T_ORI,   1, E_DEC,   "ori_decode");
        step(0, T_RTYPE, 1, E_IORI,  "ori_exec_latched");
        step(0, T_RTYPE, 1, E_IWB,   "ori_wb");
        step(0, T_J,     1, E_FDONE, "ori_next_fetch");

        // jump
        step(0, T_J,     1, E_DEC,   "j_decode");
        step(0, T_RTYPE, 1, E_JMP,   "j_jump");
        step(0, T_SW,    1, E_FDONE, "j_next_fetch");

        // sw interrupted by reset while waiting in MEM_WRITE
        step(0, T_SW,    1, E_DEC,   "sw_decode");
        step(0, T_RTYPE, 0, E_MADDR, "sw_addr");
        step(0, T_RTYPE, 0, E_MWR,   "sw_write_wait");
        step(1, T_RTYPE, 0, E_IDLE,  "sw_reset_drops_write");
        step(0, T_RTYPE, 1, E_IDLE,  "idle_after_sw_reset");
        step(0, T_ILL,   1, E_FDONE, "fetch_before_illegal");

        // Illegal opcode
        step(0, T_ILL,   1, E_DEC,   "illegal_decode");
`ifdef MIPS_ILLEGAL_OPCODE_TRAP_EN
        step(0, T_RTYPE, 1, E_TRAP,  "trap_enter");
        step(0, T_RTYPE, 0, E_TRAP,  "trap_sticky1");
        step(0, T_RTYPE, 1, E_TRAP,  "trap_sticky2");
`else
        step(0, T_RTYPE, 1, E_FDONE, "illegal_nop_fetch");
        step(0, T_RTYPE, 1, E_DEC,   "illegal_nop_decode");
        step(0, T_RTYPE, 1, E_REX,   "after_nop_rtype_exec");
`endif
        step(1, T_RTYPE, 1, E_IDLE,  "final_reset");
        step(0, T_RTYPE, 1, E_IDLE,  "final_idle");
        step(0, T_RTYPE, 1, E_FDONE, "final_fetch");

        // Let the monitor drain, bounded
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control unit for the multi-cycle MIPS datapath. Sits directly upstream of alu_control.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath enables and the 3-bit ALUop that alu_control combines with the function field.
- Moore FSM with a memory-ready handshake on every memory access.

Parameters:
- STATE_W, 4, width of the state register (must be 4 or greater).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC update.
- pc_write_cond  output  1  conditional PC update (branch).
- branch_ne  output  1  1 = take branch when ALU zero flag is 0 (bne).
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  output  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  latch instruction register.
- reg_write  output  1  register file write.
- reg_dst  output  1  1 = rd, 0 = rt.
- mem_to_reg  output  1  1 = MDR, 0 = ALUOut.
- alu_src_a  output  1  0 PC, 1 register A.
- alu_src_b  output  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
- ALUop  output  3  000 add, 001 sub, 010 R-type (use funct), 011 and, 100 or, 101 slt.

Behaviour:
- Reset is asynchronous and active-high. While reset is high: state = IDLE, latched opcode = 0, all outputs 0.
- Outputs are decoded from the state and the latched opcode only (Moore). Any output not listed for a state is 0.
- IDLE:
  - All outputs 0.
  - Next state is FETCH unconditionally.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUop=000.
  - Stay in FETCH while mem_ready=0.
  - On mem_ready=1: ir_write=1 and pc_write=1 in that cycle only, then go to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, ALUop=000 (branch target into ALUOut).
  - The opcode input is registered on this edge. Later states use only the latched copy.
  - Next state by opcode:
    - 000000 → R_EXEC
    - 100011 or 101011 → MEM_ADDR
    - 000100 or 000101 → BRANCH
    - 000010 → JUMP
    - 001000, 001100, 001101, 001010 → I_EXEC
    - any other value → see Optional Feature.
- R_EXEC: alu_src_a=1, alu_src_b=00, ALUop=010. Next: R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, ALUop=000.
  - Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ:
  - Outputs: mem_read=1, i_or_d=1.
  - Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, i_or_d=1.
  - Wait for mem_ready, then go to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, ALUop=001, pc_write_cond=1, pc_src=01.
  - branch_ne = latched opcode[0].
  - Next: FETCH.
- JUMP: pc_write=1, pc_src=10. Next: FETCH.
- I_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - ALUop by instruction: addi→000, andi→011, ori→100, slti→101.
  - Next: I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- Instruction latency when mem_ready is 1 immediately:
  - R-type, addi, andi, ori, slti: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, j: 3 cycles.
  - Each mem_ready=0 cycle in a memory state adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.
- mem_read and mem_write are never both high in the same cycle.
- Reset asserted mid-instruction: the FSM returns to IDLE immediately. No partial write-enable remains high after reset asserts.
- Unreachable state encodings go to IDLE.

Optional Feature:
- Macro: MIPS_ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to a TRAP state.
  - In TRAP, an extra output port trap (1 bit) is 1 and all other outputs are 0.
  - TRAP is sticky until reset.
- Undefined:
  - No trap port.
  - An unknown opcode goes from DECODE to FETCH, so the instruction executes as a 2-cycle no-op.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI;
  - ALUop constants: ALUOP_ADD, SUB, RTYPE, AND, OR, SLT;
  - the state encoding.
- One sub-module, mips_ctrl_output_decode: purely combinational mapping from (state, latched opcode) to the control word. The top level holds the state register, the opcode register and the next-state logic.

Test Plan:
- Reset high for 2 cycles then release, mem_ready=1 → all outputs 0 during reset; IDLE then FETCH; mem_read=1, ir_write=1, pc_write=1, ALUop=000.
- opcode=000000, mem_ready=1 → R_EXEC shows ALUop=010, alu_src_a=1, alu_src_b=00. R_WB shows reg_write=1, reg_dst=1. Back in FETCH at cycle 5.
- opcode=100011, mem_ready low for 3 cycles in MEM_READ → mem_read=1, i_or_d=1 held for 4 cycles. MEM_WB shows reg_write=1, mem_to_reg=1.
- opcode=000101 → BRANCH shows ALUop=001, pc_write_cond=1, branch_ne=1, pc_src=01. opcode=000100 gives branch_ne=0.
- opcode=001101, then opcode changed to 000000 during I_EXEC → ALUop stays 100 (latched opcode), then I_WB shows reg_write=1, reg_dst=0.
- opcode=111111 → with MIPS_ILLEGAL_OPCODE_TRAP_EN, trap=1 and held until reset; without it, FETCH follows DECODE. Also assert reset during MEM_WRITE → mem_write drops to 0 in the same cycle.
